// File: rtl/store_formatter.sv
// Store-path formatter: narrows register data into SB/SH/SW byte-lane writes
// and holds each write on a req/ack memory port, flagging bad stores and timeouts.
module store_formatter #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [1:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        st_done,
   output logic        st_err,
   output logic [1:0]  err_code,
   output logic [31:0] err_addr,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack
);

   typedef enum logic {IDLE, REQ} state_e;

   state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic [31:0] eaddr_q, eaddr_d;

   logic [31:0] lane_wdata;
   logic [3:0]  lane_be;
   logic        misaligned;

   always_comb begin
      lane_wdata = st_data;
      lane_be    = 4'b1111;
      case (st_op)
         2'b00: begin
            lane_wdata = {4{st_data[7:0]}};
            lane_be    = 4'b0001 << st_addr[1:0];
         end
         2'b01: begin
            lane_wdata = {2{st_data[15:0]}};
            lane_be    = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
      misaligned = ((st_op == 2'b01) && st_addr[0]) ||
                   ((st_op == 2'b10) && (st_addr[1:0] != 2'b00));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      eaddr_d = eaddr_q;
      case (state_q)
         IDLE: begin
            if (st_valid) begin
               if (st_op == 2'b11) begin
                  err_d   = 1'b1;
                  code_d  = 2'b10;
                  eaddr_d = st_addr;
               end else if (misaligned) begin
                  err_d   = 1'b1;
                  code_d  = 2'b01;
                  eaddr_d = st_addr;
               end else begin
                  state_d = REQ;
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  maddr_d = {st_addr[31:2], 2'b00};
                  wdata_d = lane_wdata;
                  be_d    = lane_be;
               end
            end
         end
         REQ: begin
            // ack is checked before the limit so a last-cycle ack still commits
            if (mem_ack) begin
               state_d = IDLE;
               req_d   = 1'b0;
               be_d    = '0;
               done_d  = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = IDLE;
               req_d   = 1'b0;
               be_d    = '0;
               err_d   = 1'b1;
               code_d  = 2'b11;
               eaddr_d = maddr_q;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         maddr_q <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
         eaddr_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         eaddr_q <= eaddr_d;
      end
   end

   assign st_ready  = (state_q == IDLE);
   assign st_done   = done_q;
   assign st_err    = err_q;
   assign err_code  = code_q;
   assign err_addr  = eaddr_q;
   assign mem_req   = req_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;

endmodule

// File: tb/tb_store_formatter.sv
// Directed bench for store_formatter: table of single stores plus
// hand-written wait-state, timeout, back-to-back and async-reset sequences.
module tb_store_formatter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_valid;
   logic        st_ready;
   logic [1:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        st_done;
   logic        st_err;
   logic [1:0]  err_code;
   logic [31:0] err_addr;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   store_formatter #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
      .st_addr(st_addr), .st_data(st_data),
      .st_done(st_done), .st_err(st_err), .err_code(err_code), .err_addr(err_addr),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic        exp_err;
      logic [1:0]  exp_code;
      logic [31:0] exp_maddr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{2'b00, 32'h0000_1003, 32'hAABB_CCDD, 1'b0, 2'b00, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000};
      vecs[1]  = '{2'b00, 32'h0000_1000, 32'h1122_3344, 1'b0, 2'b00, 32'h0000_1000, 32'h4444_4444, 4'b0001};
      vecs[2]  = '{2'b00, 32'h0000_1001, 32'h1122_3344, 1'b0, 2'b00, 32'h0000_1000, 32'h4444_4444, 4'b0010};
      vecs[3]  = '{2'b01, 32'h0000_2002, 32'h1234_5678, 1'b0, 2'b00, 32'h0000_2000, 32'h5678_5678, 4'b1100};
      vecs[4]  = '{2'b01, 32'h0000_2000, 32'hCAFE_BEEF, 1'b0, 2'b00, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011};
      vecs[5]  = '{2'b10, 32'h0000_2008, 32'hDEAD_0001, 1'b0, 2'b00, 32'h0000_2008, 32'hDEAD_0001, 4'b1111};
      vecs[6]  = '{2'b10, 32'h0000_3001, 32'h0000_0000, 1'b1, 2'b01, 32'h0, 32'h0, 4'b0000};
      vecs[7]  = '{2'b01, 32'h0000_3003, 32'h0000_0000, 1'b1, 2'b01, 32'h0, 32'h0, 4'b0000};
      vecs[8]  = '{2'b10, 32'h0000_3002, 32'h0000_0000, 1'b1, 2'b01, 32'h0, 32'h0, 4'b0000};
      vecs[9]  = '{2'b11, 32'h0000_5000, 32'h0000_0000, 1'b1, 2'b10, 32'h0, 32'h0, 4'b0000};
      vecs[10] = '{2'b11, 32'h0000_5001, 32'h0000_0000, 1'b1, 2'b10, 32'h0, 32'h0, 4'b0000};

      rst_n = 1'b0; st_valid = 1'b0; st_op = '0; st_addr = '0; st_data = '0; mem_ack = 1'b0;
      #22;
      chk("rst_ready", 32'(st_ready), 32'd1);
      chk("rst_req",   32'(mem_req),  32'd0);
      chk("rst_be",    32'(mem_be),   32'd0);
      chk("rst_code",  32'(err_code), 32'd0);
      rst_n = 1'b1;
      tick();

      // table-driven single stores, one-cycle ack
      for (int i = 0; i < 11; i++) begin
         st_valid = 1'b1; st_op = vecs[i].op; st_addr = vecs[i].addr; st_data = vecs[i].data;
         tick();
         st_valid = 1'b0;
         if (vecs[i].exp_err) begin
            chk($sformatf("v%0d_err", i),   32'(st_err),   32'd1);
            chk($sformatf("v%0d_code", i),  32'(err_code), 32'(vecs[i].exp_code));
            chk($sformatf("v%0d_eaddr", i), err_addr,      vecs[i].addr);
            chk($sformatf("v%0d_noreq", i), 32'(mem_req),  32'd0);
            chk($sformatf("v%0d_nodone", i), 32'(st_done), 32'd0);
            tick();
            chk($sformatf("v%0d_errpulse", i), 32'(st_err), 32'd0);
            chk($sformatf("v%0d_noreq2", i),   32'(mem_req), 32'd0);
         end else begin
            chk($sformatf("v%0d_req", i),   32'(mem_req),  32'd1);
            chk($sformatf("v%0d_maddr", i), mem_addr,      vecs[i].exp_maddr);
            chk($sformatf("v%0d_wdata", i), mem_wdata,     vecs[i].exp_wdata);
            chk($sformatf("v%0d_be", i),    32'(mem_be),   32'(vecs[i].exp_be));
            chk($sformatf("v%0d_busy", i),  32'(st_ready), 32'd0);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            chk($sformatf("v%0d_done", i),   32'(st_done),  32'd1);
            chk($sformatf("v%0d_noerr", i),  32'(st_err),   32'd0);
            chk($sformatf("v%0d_reqoff", i), 32'(mem_req),  32'd0);
            chk($sformatf("v%0d_beoff", i),  32'(mem_be),   32'd0);
            chk($sformatf("v%0d_ready", i),  32'(st_ready), 32'd1);
            tick();
            chk($sformatf("v%0d_donepulse", i), 32'(st_done), 32'd0);
         end
      end

      // SW with three wait cycles; held request must not move
      st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h0000_2004; st_data = 32'h1234_5678;
      tick();
      st_valid = 1'b0; st_data = 32'hFFFF_FFFF; st_addr = 32'h0000_9999;
      for (int w = 0; w < 4; w++) begin
         chk($sformatf("wait%0d_req", w),   32'(mem_req),  32'd1);
         chk($sformatf("wait%0d_addr", w),  mem_addr,      32'h0000_2004);
         chk($sformatf("wait%0d_wdata", w), mem_wdata,     32'h1234_5678);
         chk($sformatf("wait%0d_be", w),    32'(mem_be),   32'hF);
         chk($sformatf("wait%0d_busy", w),  32'(st_ready), 32'd0);
         if (w == 3) mem_ack = 1'b1;
         tick();
      end
      mem_ack = 1'b0;
      chk("wait_done", 32'(st_done), 32'd1);

      // timeout: ack never comes; valid held during REQ is ignored
      tick();
      st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h0000_4000; st_data = 32'h0BAD_F00D;
      tick();
      for (int c = 1; c <= 15; c++) begin
         tick();
         chk($sformatf("to_req%0d", c), 32'(mem_req), 32'd1);
         chk($sformatf("to_quiet%0d", c), 32'(st_err | st_done), 32'd0);
      end
      st_valid = 1'b0;
      tick();
      chk("to_reqoff", 32'(mem_req),  32'd0);
      chk("to_err",    32'(st_err),   32'd1);
      chk("to_done",   32'(st_done),  32'd0);
      chk("to_code",   32'(err_code), 32'd3);
      chk("to_eaddr",  err_addr,      32'h0000_4000);
      chk("to_ready",  32'(st_ready), 32'd1);
      tick();

      // ack arriving in the final permitted cycle wins over timeout
      st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h0000_4004; st_data = 32'h0000_0016;
      tick();
      st_valid = 1'b0;
      for (int c = 1; c <= 15; c++) tick();
      chk("late_req", 32'(mem_req), 32'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("late_done",  32'(st_done),  32'd1);
      chk("late_noerr", 32'(st_err),   32'd0);
      chk("late_code",  32'(err_code), 32'd3);
      tick();

      // back-to-back with ack always high: one commit every two cycles
      begin
         int unsigned ndone = 0;
         st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h0000_6000; st_data = 32'h0606_0606;
         mem_ack = 1'b1;
         tick();
         for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin st_valid = 1'b0; end
            tick();
            if (st_done) ndone++;
            chk($sformatf("b2b_done%0d", c), 32'(st_done), 32'(c % 2));
            chk($sformatf("b2b_excl%0d", c), 32'(st_done & st_err), 32'd0);
         end
         chk("b2b_count", 32'(ndone), 32'd4);
         tick();
         chk("idle_ack_ignored", 32'(mem_req | st_done), 32'd0);
         mem_ack = 1'b0;
      end

      // asynchronous reset between edges while a request is in flight
      st_valid = 1'b1; st_op = 2'b10; st_addr = 32'h0000_7000; st_data = 32'h7777_7777;
      tick();
      st_valid = 1'b0;
      chk("ar_req_before", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_req_async", 32'(mem_req), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_ready", 32'(st_ready),  32'd1);
      chk("ar_addr",  mem_addr,       32'd0);
      chk("ar_wdata", mem_wdata,      32'd0);
      chk("ar_be",    32'(mem_be),    32'd0);
      chk("ar_flags", 32'({st_done, st_err, mem_req}), 32'd0);
      chk("ar_code",  32'(err_code),  32'd0);
      chk("ar_eaddr", err_addr,       32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
